// File: rtl/prll_bs_drvr_fifo.sv
// rtl/prll_bs_drvr_fifo.sv - per-driver TX/RX FWFT FIFO pair between host logic and the parallel bus
// Optional DRVR_ID_STAMP_EN: overwrite the source field of TX writes with DRVR_ID.
module prll_bs_drvr_fifo #(
  parameter int         BITS      = 32,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] DRVR_ID   = 8'd0,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_push,
  input  logic [BITS-1:0]          host_D_in,
  output logic                     host_full,
  output logic                     pndng,
  output logic [BITS-1:0]          D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [BITS-1:0]          D_push,
  output logic                     host_pndng,
  output logic [BITS-1:0]          host_D_out,
  input  logic                     host_pop,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_ovf,
  output logic                     rx_misroute,
  input  logic                     flag_clr
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [BITS-1:0] tx_mem [DEPTH];
  logic [BITS-1:0] rx_mem [DEPTH];
  logic [AW-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic [BITS-1:0] tx_wdata;
  logic            tx_wr, tx_rd, rx_wr, rx_rd;
  logic            rx_full, rx_hit, ovf_set, mis_set;

`ifdef DRVR_ID_STAMP_EN
  assign tx_wdata = {host_D_in[BITS-1:BITS-8], DRVR_ID, host_D_in[BITS-17:0]};
`else
  assign tx_wdata = host_D_in;
`endif

  assign pndng      = (tx_count != '0);
  assign host_full  = (tx_count == FULL_CNT);
  assign host_pndng = (rx_count != '0);
  assign rx_full    = (rx_count == FULL_CNT);

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign tx_rd = pop && pndng;
  assign tx_wr = host_push && (!host_full || tx_rd);

  assign rx_hit  = (D_push[BITS-1:BITS-8] == DRVR_ID) || (D_push[BITS-1:BITS-8] == BROADCAST);
  assign rx_rd   = host_pop && host_pndng;
  assign rx_wr   = push && rx_hit && (!rx_full || rx_rd);
  assign ovf_set = push && rx_hit && rx_full && !rx_rd;
  assign mis_set = push && !rx_hit;

  assign D_pop      = pndng      ? tx_mem[tx_rp] : '0;
  assign host_D_out = host_pndng ? rx_mem[rx_rp] : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= tx_wdata;
    if (rx_wr) rx_mem[rx_wp] <= D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_count    <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_count    <= '0;
      rx_ovf      <= 1'b0;
      rx_misroute <= 1'b0;
    end else begin
      if (tx_wr) tx_wp <= tx_wp + AW'(1);
      if (tx_rd) tx_rp <= tx_rp + AW'(1);
      tx_count <= tx_count + CW'(tx_wr) - CW'(tx_rd);
      if (rx_wr) rx_wp <= rx_wp + AW'(1);
      if (rx_rd) rx_rp <= rx_rp + AW'(1);
      rx_count <= rx_count + CW'(rx_wr) - CW'(rx_rd);
      // Set has priority over a simultaneous clear.
      if (ovf_set)       rx_ovf <= 1'b1;
      else if (flag_clr) rx_ovf <= 1'b0;
      if (mis_set)       rx_misroute <= 1'b1;
      else if (flag_clr) rx_misroute <= 1'b0;
    end
  end

endmodule
